// File: rtl/memory_access_cycle_if.sv
// -----------------------------------------------------------------------------
// memory_access_cycle_if
//
// Data-memory request/acknowledge bus between the Memory pipeline stage
// (master) and the data memory (slave).
//
//   dmem_req    master->slave  level request, held until ack or timeout
//   dmem_we     master->slave  1 = write, 0 = read (valid while dmem_req)
//   dmem_addr   master->slave  word-aligned byte address
//   dmem_wdata  master->slave  store data
//   dmem_ack    slave->master  completion; dmem_rdata valid in same cycle
//   dmem_rdata  slave->master  load data
// -----------------------------------------------------------------------------
interface memory_access_cycle_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/memory_access_cycle.sv
// -----------------------------------------------------------------------------
// memory_access_cycle
//
// Memory stage of the five-stage RISC-V pipeline. Issues loads/stores over a
// req/ack data-memory bus with a bounded wait, stalls F/D/E/M while the memory
// is busy, and holds the Memory->Writeback pipeline register.
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles dmem_req may stay high unacked (1..255)
//
// Optional feature (compile-time macro MEM_ALIGN_CHECK_EN):
//   defined   - accesses with ALUResultM[1:0] != 0 issue no request, retire
//               with RegWriteW=0 and raise the extra output MisalignW.
//   undefined - low address bits are ignored; no MisalignW port.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   RegWriteM..PCPlus4M  Execute->Memory pipeline fields
//   dmem                 data-memory bus (master side)
//   StallM               freezes the F, D, E and M pipeline registers
//   RegWriteW..PCPlus4W  Memory->Writeback pipeline register
//   BusErrW              instruction in W timed out on the bus
//   MisalignW            instruction in W was misaligned (macro only)
// -----------------------------------------------------------------------------
module memory_access_cycle #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,

  memory_access_cycle_if.master dmem,

  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        MisalignW,
`endif
  output logic        BusErrW
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [7:0] cnt_cur;

  logic is_load;
  logic access;
  logic misalign;
  logic mem_access;
  logic timeout;
  logic stall;

  assign is_load = (ResultSrcM == 2'b01);
  assign access  = MemWriteM | is_load;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = access & (ALUResultM[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign mem_access = access & ~misalign;

  // Bus outputs are gated by rst so they drop the instant reset asserts,
  // not at the next clock edge. While stalled the M inputs are frozen
  // upstream, so addr/we/wdata stay stable for the whole transaction.
  assign dmem.dmem_req   = rst & mem_access;
  assign dmem.dmem_we    = dmem.dmem_req & MemWriteM;
  assign dmem.dmem_addr  = rst ? {ALUResultM[31:2], 2'b00} : 32'd0;
  assign dmem.dmem_wdata = rst ? WriteDataM : 32'd0;

  // Cycles already spent waiting: 0 in the request's first (IDLE) cycle.
  assign cnt_cur = (state == WAIT) ? cnt : 8'd0;

  // Ack has priority over timeout in the last allowed cycle.
  assign timeout = dmem.dmem_req & ~dmem.dmem_ack & (cnt_cur == TIMEOUT_LAST);
  assign stall   = dmem.dmem_req & ~dmem.dmem_ack & ~timeout;
  assign StallM  = stall;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking (<=) so every register
      // samples pre-edge values regardless of statement order.
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state / wait counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned, which
    // would otherwise infer a latch.
    state_next = IDLE;
    cnt_next   = 8'd0;
    unique case (state)
      IDLE: begin
        if (stall) begin
          state_next = WAIT;
          cnt_next   = 8'd1;
        end
      end
      WAIT: begin
        if (stall) begin
          state_next = WAIT;
          cnt_next   = cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory -> Writeback pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      RdW        <= 5'd0;
      PCPlus4W   <= 32'd0;
      BusErrW    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      MisalignW  <= 1'b0;
`endif
    end else if (stall) begin
      // Bubble: the M instruction is still waiting on the bus.
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      RdW        <= 5'd0;
      PCPlus4W   <= 32'd0;
      BusErrW    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      MisalignW  <= 1'b0;
`endif
    end else begin
      // Normal completion, non-access, timeout or misaligned retirement.
      // Faulted instructions retire but must not write the register file.
      RegWriteW  <= RegWriteM & ~timeout & ~misalign;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= (is_load & dmem.dmem_req & dmem.dmem_ack) ? dmem.dmem_rdata : 32'd0;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      BusErrW    <= timeout;
`ifdef MEM_ALIGN_CHECK_EN
      MisalignW  <= misalign;
`endif
    end
  end

endmodule
